random_source_lfsr: RTL
=======================

Name: random_source_lfsr

Overview:
Seedable pseudo-random source that directly feeds the 3-symbol permutation mapper with its 7-bit `random` select value.
- A 16-bit Galois LFSR drives a valid/ready handshake.
- Each accepted word selects exactly one permutation; the LFSR advances only on acceptance.
- An optional warm-up phase follows every (re)seed.
- A draw counter supports bench and system statistics.

Parameters:
LFSR_WIDTH, 16, LFSR state width
OUT_WIDTH, 7, width of random_out (must be <= LFSR_WIDTH)
TAPS, 16'hB400, Galois feedback mask (maximal-length for 16 bits)
DEFAULT_SEED, 16'hACE1, seed used at reset and to replace an all-zero seed
WARMUP, 8, LFSR steps discarded after reset/seed load (0 allowed)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
seed_load  input  1  one-cycle request to reload LFSR from seed_in
seed_in  input  LFSR_WIDTH  new seed value
enable  input  1  permits generation of new valid words
random_out  output  OUT_WIDTH  LFSR bits [OUT_WIDTH-1:0], to mapper `random` input
random_valid  output  1  random_out holds an unconsumed word
random_ready  input  1  consumer accepts word when high with random_valid
draw_count  output  16  number of accepted words, wraps modulo 2^16
busy  output  1  high while in WARMUP state

Behaviour:
- Reset (async, rst=1):
  - lfsr=DEFAULT_SEED, state=WARMUP (or RUN if WARMUP=0), warm counter=0.
  - random_valid=0, draw_count=0, busy=(WARMUP!=0).
  - random_out reflects lfsr at all times, so it equals DEFAULT_SEED[OUT_WIDTH-1:0] during reset.
- LFSR step:
  - b=lfsr[0]; lfsr = (lfsr>>1) ^ (b ? TAPS : 0).
  - The all-zero state is never entered: a zero seed is replaced by DEFAULT_SEED.
- States:
  - WARMUP: one step per cycle, random_valid=0, busy=1. After WARMUP steps, go to RUN; busy falls on the same edge.
  - RUN:
    - If random_valid=0 and enable=1, set random_valid next cycle without stepping.
    - On random_valid & random_ready: step the LFSR and increment draw_count on that edge. random_valid stays 1 if enable=1, otherwise clears.
    - A word is therefore available every cycle under continuous ready+enable (throughput 1/cycle, no bubble).
- Handshake rules:
  - While random_valid=1 and random_ready=0, random_out is held stable.
  - Deasserting enable does not withdraw a pending valid word; random_valid drops only on accept or seed_load.
- seed_load (any state, highest priority after rst):
  - lfsr=(seed_in==0 ? DEFAULT_SEED : seed_in), random_valid=0, warm counter=0.
  - state=WARMUP (RUN if WARMUP=0).
  - A simultaneous accept in that cycle is discarded: no step, and draw_count is not incremented.
  - draw_count is not cleared by seed_load.
- draw_count wraps from 16'hFFFF to 0.
- Reset mid-warmup or mid-handshake: immediate return to reset values; no partial word is presented.
- Output widths are exact; there is no re-mapping of value ranges. The mapper performs the range-to-permutation binning.

Test Plan:
1. WARMUP=2, reset with seed 0xACE1, enable=1, ready=0 -> LFSR steps 0xE270 then 0x7138. random_valid rises one cycle after busy falls, with random_out=7'h38, held stable for 10 cycles.
2. Continuing test 1, ready=1 for 2 cycles -> accepts 7'h38 then 7'h1C (lfsr 0x389C); draw_count=2; random_valid stays 1.
3. seed_load=1 with seed_in=0 together with random_valid&random_ready -> lfsr=0xACE1, random_valid=0, draw_count unchanged, busy=1 for WARMUP cycles.
4. enable=0 while a word is pending -> random_valid stays 1 until accept, then 0. No further valid until enable=1.
5. Continuous ready/enable for 70000 accepts -> draw_count wraps (reads 70000-65536=4464). lfsr is never 0; the sequence period is 65535.
6. rst pulse asserted asynchronously mid-WARMUP and mid-handshake -> outputs immediately take reset values. After release, the sequence restarts identically to test 1.

Source files
------------

// File: rtl/random_source_lfsr.sv
// Seedable 16-bit Galois LFSR random source with a valid/ready handshake,
// optional post-seed warm-up and a wrapping accepted-word counter.
module random_source_lfsr #(
  parameter int unsigned            LFSR_WIDTH   = 16,
  parameter int unsigned            OUT_WIDTH    = 7,
  parameter logic [LFSR_WIDTH-1:0]  TAPS         = 16'hB400,
  parameter logic [LFSR_WIDTH-1:0]  DEFAULT_SEED = 16'hACE1,
  parameter int unsigned            WARMUP       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  seed_load,
  input  logic [LFSR_WIDTH-1:0] seed_in,
  input  logic                  enable,
  output logic [OUT_WIDTH-1:0]  random_out,
  output logic                  random_valid,
  input  logic                  random_ready,
  output logic [15:0]           draw_count,
  output logic                  busy
);

  localparam int unsigned WCW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [WCW-1:0] WARM_LAST = WCW'((WARMUP == 0) ? 0 : WARMUP - 1);

  typedef enum logic {S_WARMUP, S_RUN} state_t;
  localparam state_t INIT_STATE = (WARMUP != 0) ? S_WARMUP : S_RUN;
  localparam logic   INIT_BUSY  = (WARMUP != 0);

  state_t                  state;
  logic [LFSR_WIDTH-1:0]   lfsr;
  logic [WCW-1:0]          warm_cnt;

  function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] v);
    return (v >> 1) ^ (v[0] ? TAPS : '0);
  endfunction

  assign random_out = lfsr[OUT_WIDTH-1:0];

  // seed_load outranks an accept in the same cycle, so that word is dropped uncounted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= INIT_STATE;
      lfsr         <= DEFAULT_SEED;
      warm_cnt     <= '0;
      random_valid <= 1'b0;
      draw_count   <= '0;
      busy         <= INIT_BUSY;
    end else if (seed_load) begin
      state        <= INIT_STATE;
      lfsr         <= (seed_in == '0) ? DEFAULT_SEED : seed_in;
      warm_cnt     <= '0;
      random_valid <= 1'b0;
      busy         <= INIT_BUSY;
    end else begin
      case (state)
        S_WARMUP: begin
          lfsr <= lfsr_step(lfsr);
          if (warm_cnt == WARM_LAST) begin
            state    <= S_RUN;
            busy     <= 1'b0;
            warm_cnt <= '0;
          end else begin
            warm_cnt <= warm_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (random_valid && random_ready) begin
            lfsr         <= lfsr_step(lfsr);
            draw_count   <= draw_count + 16'd1;
            random_valid <= enable;
          end else if (!random_valid && enable) begin
            random_valid <= 1'b1;
          end
        end
        default: begin
          state <= INIT_STATE;
          busy  <= INIT_BUSY;
        end
      endcase
    end
  end

endmodule
